memory_stage_lsu: RTL

Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and drives a single-port, ready-handshaked data-memory bus. It formats byte, halfword and word loads and stores, and stalls the pipeline while an access is outstanding. Its ReadDataM output feeds the MEM/WB pipeline register, and its StallM output goes to the hazard unit, which freezes the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/memory_stage_lsu.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/memory_stage_lsu.sv
// Memory-stage load/store unit: formats B/H/W loads and stores onto a ready-handshaked
// data bus and stalls the pipeline while an access is outstanding. Optional macro: MISALIGN_TRAP_EN.
module memory_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM,
    output logic        MisalignM,
    output logic        fsm_state
);

    // Bus handshake: a transfer completes in any cycle where dmem_req and dmem_ready
    // are both high; request fields stay valid because upstream stages are stalled.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt, cnt_next;

    logic [1:0]  a;
    logic        is_load, access, eff_load, is_b, is_h, unsigned_ld, misalign;
    logic [3:0]  be;
    logic [31:0] wdata, load_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign a           = ALUResultM[1:0];
    assign is_load     = (ResultSrcM == 2'b01);
    assign access      = MemWriteM | is_load;
    assign eff_load    = is_load & ~MemWriteM;
    assign is_b        = (Funct3M[1:0] == 2'b00);
    assign is_h        = (Funct3M[1:0] == 2'b01);
    assign unsigned_ld = Funct3M[2];

`ifdef MISALIGN_TRAP_EN
    assign misalign = access & ((is_h & a[0]) | (~is_b & ~is_h & (a != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        be    = 4'b1111;
        wdata = WriteDataM;
        if (is_b) begin
            be    = 4'b0001 << a;
            wdata = {4{WriteDataM[7:0]}};
        end else if (is_h) begin
            be    = 4'b0011 << {a[1], 1'b0};
            wdata = {2{WriteDataM[15:0]}};
        end
    end

    always_comb begin
        case (a)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (is_b)
            load_val = {{24{~unsigned_ld & ld_byte[7]}}, ld_byte};
        else if (is_h)
            load_val = {{16{~unsigned_ld & ld_half[15]}}, ld_half};
        else
            load_val = dmem_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    assign fsm_state = state;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        ReadDataM  = '0;
        StallM     = 1'b0;
        BusErrM    = 1'b0;
        MisalignM  = 1'b0;
        // Every output stays at zero while reset is asserted, even mid-access.
        if (reset_n) begin
            dmem_addr = {ALUResultM[31:2], 2'b00};
            case (state)
                S_IDLE: begin
                    if (access && misalign) begin
                        MisalignM = 1'b1;
                    end else if (access) begin
                        dmem_req   = 1'b1;
                        dmem_we    = MemWriteM;
                        dmem_be    = be;
                        dmem_wdata = wdata;
                        if (dmem_ready) begin
                            ReadDataM = eff_load ? load_val : 32'd0;
                        end else begin
                            StallM     = 1'b1;
                            cnt_next   = CW'(1);
                            next_state = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == CW'(TIMEOUT)) begin
                        // Error cycle: a late ready is deliberately ignored.
                        BusErrM    = 1'b1;
                        cnt_next   = '0;
                        next_state = S_IDLE;
                    end else begin
                        dmem_req   = 1'b1;
                        dmem_we    = MemWriteM;
                        dmem_be    = be;
                        dmem_wdata = wdata;
                        if (dmem_ready) begin
                            ReadDataM  = eff_load ? load_val : 32'd0;
                            cnt_next   = '0;
                            next_state = S_IDLE;
                        end else begin
                            StallM   = 1'b1;
                            cnt_next = cnt + CW'(1);
                        end
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

endmodule
